rat_intr_controller: RTL and testbench

- CPU-side receiver for the interrupt lines that the button interrupt generators drive; each generator holds its line high for 6 CLK cycles per press.
- Detects a rising edge on each source and latches it as pending.
- Gates pending events with the CPU interrupt-enable flag (I) and presents one prioritised request plus a vector to the control unit FSM.
- Tracks the in-service window between acknowledge and RETIE.

---
 rtl/rat_intr_pkg.sv | 24 ++
 rtl/rat_intr_edge_detect.sv | 46 ++++
 rtl/rat_intr_controller.sv | 131 +++++++++++++
 tb/tb_rat_intr_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rat_intr_pkg.sv
// Shared types and helpers for the interrupt controller.
package rat_intr_pkg;

    localparam int unsigned DEFAULT_NUM_SRC = 4;
    // Widest source vector the priority encoder handles
    localparam int unsigned MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } intr_state_t;

    // Index of the lowest set bit; 0 when nothing is set
    function automatic logic [2:0] prio_enc(input logic [MAX_SRC-1:0] pending);
        prio_enc = '0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (pending[i]) begin
                prio_enc = 3'(i);
            end
        end
    endfunction

endpackage

// File: rtl/rat_intr_edge_detect.sv
// Per-source rising-edge detector producing a one-cycle pulse.
// Optional 2-flop input synchroniser enabled by macro RAT_INTR_SYNC_EN.
module rat_intr_edge_detect (
    input  logic CLK,
    input  logic RST,
    input  logic intr_i,
    output logic edge_o
);

    logic sampled;
    logic prev_q;

`ifdef RAT_INTR_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Two-stage synchroniser for an asynchronous interrupt line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= intr_i;
            sync2_q <= sync1_q;
        end
    end

    assign sampled = sync2_q;
`else
    // Line is assumed synchronous to CLK
    assign sampled = intr_i;
`endif

    // Previous-cycle copy of the line for edge detection
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sampled;
        end
    end

    // A held-high line yields only one pulse
    assign edge_o = sampled & ~prev_q;

endmodule

// File: rtl/rat_intr_controller.sv
// CPU-side interrupt controller: edge capture, pending latch, I-flag gating,
// lowest-index priority and in-service tracking between acknowledge and RETIE.
// Optional input synchroniser: define RAT_INTR_SYNC_EN.
module rat_intr_controller
    import rat_intr_pkg::*;
#(
    parameter int unsigned NUM_SRC = DEFAULT_NUM_SRC,
    localparam int unsigned VEC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] INTR,
    input  logic               SEI,
    input  logic               CLI,
    input  logic               RETIE,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic [VEC_W-1:0]   INT_VEC,
    output logic               I_FLAG,
    output logic               IN_ISR,
    output logic [NUM_SRC-1:0] DROPPED
);

    intr_state_t        state_q;
    logic               i_flag_q;
    logic               in_isr_q;
    logic [VEC_W-1:0]   vec_q;
    logic [NUM_SRC-1:0] pending_q;
    logic [NUM_SRC-1:0] dropped_q;

    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] clr_mask;
    logic [MAX_SRC-1:0] pend_ext;
    logic [VEC_W-1:0]   vec_next;
    logic               ack_take;
    logic               retie_take;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_edge
        rat_intr_edge_detect u_edge (
            .CLK    (CLK),
            .RST    (RST),
            .intr_i (INTR[g]),
            .edge_o (edges[g])
        );
    end

    assign ack_take   = (state_q == REQ) && INT_ACK;
    assign retie_take = (state_q == SERVICE) && RETIE;

    // Widen pending for the shared encoder and pick the winning source
    always_comb begin
        pend_ext = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_ext[i] = pending_q[i];
        end
        vec_next = VEC_W'(prio_enc(pend_ext));
    end

    // One-hot clear of the acknowledged source
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_mask[i] = ack_take && (vec_q == VEC_W'(i));
        end
    end

    // Pending latch (set beats clear) and sticky overflow flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending_q <= '0;
            dropped_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | edges;
            dropped_q <= dropped_q | (edges & pending_q);
        end
    end

    // Control FSM with registered I flag, in-service flag and vector
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            i_flag_q <= 1'b0;
            in_isr_q <= 1'b0;
            vec_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    vec_q <= vec_next;
                    if (CLI) begin
                        i_flag_q <= 1'b0;
                    end else if (SEI) begin
                        i_flag_q <= 1'b1;
                    end
                    if (i_flag_q && (pending_q != '0)) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        i_flag_q <= 1'b0;
                        in_isr_q <= 1'b1;
                        state_q  <= SERVICE;
                    end else if (CLI) begin
                        i_flag_q <= 1'b0;
                        state_q  <= IDLE;
                    end else if (SEI) begin
                        i_flag_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    // Only RETIE restores I here; SEI is ignored
                    if (retie_take) begin
                        i_flag_q <= 1'b1;
                        in_isr_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign INT_REQ = (state_q == REQ);
    assign INT_VEC = vec_q;
    assign I_FLAG  = i_flag_q;
    assign IN_ISR  = in_isr_q;
    assign DROPPED = dropped_q;

endmodule

// File: tb/tb_rat_intr_controller.sv
// Directed bench with a behavioural reference model for rat_intr_controller.
module tb_rat_intr_controller;

    localparam int unsigned N = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic [N-1:0] INTR = '0;
    logic         SEI = 1'b0;
    logic         CLI = 1'b0;
    logic         RETIE = 1'b0;
    logic         INT_ACK = 1'b0;
    logic         INT_REQ;
    logic [1:0]   INT_VEC;
    logic         I_FLAG;
    logic         IN_ISR;
    logic [N-1:0] DROPPED;

    int checks = 0;
    int fails  = 0;
    int req_count = 0;
    logic req_seen = 1'b0;

    rat_intr_controller #(.NUM_SRC(N)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .INTR    (INTR),
        .SEI     (SEI),
        .CLI     (CLI),
        .RETIE   (RETIE),
        .INT_ACK (INT_ACK),
        .INT_REQ (INT_REQ),
        .INT_VEC (INT_VEC),
        .I_FLAG  (I_FLAG),
        .IN_ISR  (IN_ISR),
        .DROPPED (DROPPED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: pending set, I flag and request/service phases
    bit [N-1:0] m_pend = '0, m_prev = '0, m_drop = '0;
    bit         m_i = 0, m_req = 0, m_isr = 0;
    int         m_vec = 0;

    function automatic int lowest(input bit [N-1:0] p);
        for (int i = 0; i < N; i++) if (p[i]) return i;
        return 0;
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit [N-1:0] ev;
        bit ack, ret, req_n, isr_n, i_n;
        bit [N-1:0] pend_n;
        if (RST) begin
            m_pend = '0; m_prev = '0; m_drop = '0;
            m_i = 0; m_req = 0; m_isr = 0; m_vec = 0;
        end else begin
            ev     = INTR & ~m_prev;
            m_prev = INTR;
            ack    = m_req && INT_ACK;
            ret    = m_isr && RETIE;
            m_drop = m_drop | (ev & m_pend);
            pend_n = m_pend;
            if (ack) pend_n[m_vec] = 1'b0;
            pend_n = pend_n | ev;
            i_n = m_i;
            if (ack) i_n = 0;
            else if (m_isr) begin
                if (ret) i_n = 1;
            end else if (CLI) i_n = 0;
            else if (SEI) i_n = 1;
            req_n = m_req; isr_n = m_isr;
            if (m_req) begin
                if (ack) begin req_n = 0; isr_n = 1; end
                else if (CLI) req_n = 0;
            end else if (m_isr) begin
                if (ret) isr_n = 0;
            end else if (m_i && m_pend != '0) begin
                req_n = 1;
                m_vec = lowest(m_pend);
            end
            m_pend = pend_n; m_i = i_n; m_req = req_n; m_isr = isr_n;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge CLK) begin
        check("int_req", 32'(INT_REQ), 32'(m_req));
        check("i_flag", 32'(I_FLAG), 32'(m_i));
        check("in_isr", 32'(IN_ISR), 32'(m_isr));
        check("dropped", 32'(DROPPED), 32'(m_drop));
        if (m_req) check("int_vec", 32'(INT_VEC), 32'(m_vec));
    end

    // Count distinct request assertions
    always @(posedge CLK) begin
        if (INT_REQ && !req_seen) req_count++;
        req_seen <= INT_REQ;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge CLK);
    endtask

    int base;

    initial begin
        #3;
        check("rst_req", 32'(INT_REQ), 0);
        check("rst_i", 32'(I_FLAG), 0);
        check("rst_isr", 32'(IN_ISR), 0);
        check("rst_drop", 32'(DROPPED), 0);
        check("rst_vec", 32'(INT_VEC), 0);
        tick(2);
        RST = 1'b0;
        tick();

        // Single event, 6-cycle pulse on source 2
        SEI = 1; tick(); SEI = 0;
        base = req_count;
        INTR = 4'b0100; tick();
        check("t1_req_wait", 32'(INT_REQ), 0);
        tick();
        check("t1_req", 32'(INT_REQ), 1);
        check("t1_vec", 32'(INT_VEC), 2);
        INT_ACK = 1; tick(); INT_ACK = 0;
        check("t1_isr", 32'(IN_ISR), 1);
        check("t1_i_clr", 32'(I_FLAG), 0);
        check("t1_req_off", 32'(INT_REQ), 0);
        tick(3); INTR = '0; tick(3);
        RETIE = 1; tick(); RETIE = 0;
        check("t1_i_set", 32'(I_FLAG), 1);
        check("t1_isr_off", 32'(IN_ISR), 0);
        tick(4);
        check("t1_one_req", 32'(req_count - base), 1);

        // Masked then enabled, source 1
        CLI = 1; tick(); CLI = 0;
        base = req_count;
        INTR = 4'b0010; tick(6); INTR = '0;
        tick(20);
        check("t2_masked", 32'(req_count - base), 0);
        SEI = 1; tick(); SEI = 0;
        check("t2_i_on", 32'(I_FLAG), 1);
        tick();
        check("t2_req", 32'(INT_REQ), 1);
        check("t2_vec", 32'(INT_VEC), 1);
        INT_ACK = 1; tick(); INT_ACK = 0;
        RETIE = 1; tick(); RETIE = 0;

        // Priority: sources 3 and 0 together
        INTR = 4'b1001; tick(2);
        check("t3_vec0", 32'(INT_VEC), 0);
        INT_ACK = 1; tick(); INT_ACK = 0;
        INTR = '0; tick(2);
        RETIE = 1; tick(); RETIE = 0;
        tick();
        check("t3_req2", 32'(INT_REQ), 1);
        check("t3_vec3", 32'(INT_VEC), 3);
        INT_ACK = 1; tick(); INT_ACK = 0;
        RETIE = 1; tick(); RETIE = 0;

        // Overflow on source 1 with I clear
        CLI = 1; tick(); CLI = 0;
        base = req_count;
        repeat (3) begin
            INTR = 4'b0010; tick(); INTR = '0; tick();
        end
        check("t4_dropped", 32'(DROPPED), 32'h2);
        SEI = 1; tick(); SEI = 0; tick();
        check("t4_vec", 32'(INT_VEC), 1);
        INT_ACK = 1; tick(); INT_ACK = 0;
        RETIE = 1; tick(); RETIE = 0;
        tick(4);
        check("t4_one_req", 32'(req_count - base), 1);

        // Ack/edge collision on source 0, then CLI retract
        INTR = 4'b0001; tick(); INTR = '0; tick();
        check("t5_req", 32'(INT_REQ), 1);
        INT_ACK = 1; INTR = 4'b0001; tick(); INT_ACK = 0; INTR = '0;
        check("t5_isr", 32'(IN_ISR), 1);
        tick();
        RETIE = 1; tick(); RETIE = 0;
        tick();
        check("t5_rereq", 32'(INT_REQ), 1);
        check("t5_vec", 32'(INT_VEC), 0);
        CLI = 1; tick(); CLI = 0;
        check("t5_retract", 32'(INT_REQ), 0);
        SEI = 1; tick(); SEI = 0; tick();
        check("t5_kept", 32'(INT_REQ), 1);

        // Asynchronous reset during service
        INT_ACK = 1; tick(); INT_ACK = 0;
        check("t6_isr", 32'(IN_ISR), 1);
        #2 RST = 1;
        #1;
        check("t6_rst_req", 32'(INT_REQ), 0);
        check("t6_rst_isr", 32'(IN_ISR), 0);
        check("t6_rst_i", 32'(I_FLAG), 0);
        check("t6_rst_drop", 32'(DROPPED), 0);
        check("t6_rst_vec", 32'(INT_VEC), 0);
        tick(2); RST = 0; tick();
        base = req_count;
        SEI = 1; tick(); SEI = 0; tick(5);
        check("t6_no_req", 32'(req_count - base), 0);
        INTR = 4'b1000; tick(); INTR = '0; tick();
        check("t6_fresh", 32'(INT_REQ), 1);
        check("t6_vec", 32'(INT_VEC), 3);
        tick(2);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
